// File: rtl/hpdcache_1hot_to_binary_pipe.sv
// rtl/hpdcache_1hot_to_binary_pipe.sv - registered one-hot to binary encoder with valid/ready output stage
// Flags zero and multi-hot inputs and keeps a sticky error flag plus a saturating error counter.
module hpdcache_1hot_to_binary_pipe #(
   parameter int unsigned N           = 8,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter bit          ZERO_IS_ERR = 1'b0,
   parameter int unsigned CNT_W       = 8,
   localparam int unsigned Log2N      = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [N-1:0]     in_val_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Log2N-1:0] out_bin_o,
   output logic             out_zero_o,
   output logic             out_multi_o,
   output logic             err_sticky_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   logic             valid_q, valid_d;
   logic [Log2N-1:0] bin_q, bin_d;
   logic             zero_q, zero_d;
   logic             multi_q, multi_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             err_ev;
   logic [Log2N-1:0] enc_bin;
   logic             enc_seen;
   logic             enc_multi;

   assign in_ready_o = !valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   // Single pass over the vector: a second set bit marks multi-hot, and the
   // priority direction decides whether later (higher) hits overwrite the index.
   always_comb begin
      enc_bin   = '0;
      enc_seen  = 1'b0;
      enc_multi = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (in_val_i[i]) begin
            if (enc_seen) begin
               enc_multi = 1'b1;
            end
            if (MSB_FIRST || !enc_seen) begin
               enc_bin = Log2N'(i);
            end
            enc_seen = 1'b1;
         end
      end
   end

   assign err_ev = accept && (enc_multi || (ZERO_IS_ERR && !enc_seen));

   always_comb begin
      valid_d = valid_q;
      bin_d   = bin_q;
      zero_d  = zero_q;
      multi_d = multi_q;
      if (accept) begin
         valid_d = 1'b1;
         bin_d   = enc_bin;
         zero_d  = !enc_seen;
         multi_d = enc_multi;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Clear wins over a same-cycle error event; the counter sticks at all-ones.
   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (err_ev) begin
         sticky_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= 1'b0;
         bin_q    <= '0;
         zero_q   <= 1'b0;
         multi_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         bin_q    <= bin_d;
         zero_q   <= zero_d;
         multi_q  <= multi_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid_o  = valid_q;
   assign out_bin_o    = bin_q;
   assign out_zero_o   = zero_q;
   assign out_multi_o  = multi_q;
   assign err_sticky_o = sticky_q;
   assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hpdcache_1hot_to_binary_pipe.sv
// tb/tb_hpdcache_1hot_to_binary_pipe.sv - self-checking bench for hpdcache_1hot_to_binary_pipe
// Two instances share stimulus: A = MSB-first, zero not an error, 8-bit counter; B = LSB-first, zero is an error, 2-bit counter.
module tb_hpdcache_1hot_to_binary_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_val;
   logic       out_ready;

   logic       rdy_a, vld_a, zero_a, multi_a, sticky_a;
   logic [2:0] bin_a;
   logic [7:0] cnt_a;
   logic       rdy_b, vld_b, zero_b, multi_b, sticky_b;
   logic [2:0] bin_b;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   hpdcache_1hot_to_binary_pipe #(.N(8), .MSB_FIRST(1'b1), .ZERO_IS_ERR(1'b0), .CNT_W(8)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy_a),
      .in_val_i(in_val), .out_valid_o(vld_a), .out_ready_i(out_ready), .out_bin_o(bin_a),
      .out_zero_o(zero_a), .out_multi_o(multi_a), .err_sticky_o(sticky_a), .err_cnt_o(cnt_a)
   );

   hpdcache_1hot_to_binary_pipe #(.N(8), .MSB_FIRST(1'b0), .ZERO_IS_ERR(1'b1), .CNT_W(2)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy_b),
      .in_val_i(in_val), .out_valid_o(vld_b), .out_ready_i(out_ready), .out_bin_o(bin_b),
      .out_zero_o(zero_b), .out_multi_o(multi_b), .err_sticky_o(sticky_b), .err_cnt_o(cnt_b)
   );

   typedef struct {
      logic [7:0] val;
      logic [2:0] bin_msb;
      logic [2:0] bin_lsb;
      logic       zero;
      logic       multi;
   } vec_t;

   typedef struct {
      logic [2:0] ba;
      logic [2:0] bb;
      logic       z;
      logic       m;
   } ent_t;

   vec_t tbl [10];
   ent_t sb [$];
   int   total = 0;
   int   bad   = 0;
   int   m_sticky_a, m_cnt_a, m_sticky_b, m_cnt_b;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, " valid_a"}, int'(vld_a), int'(sb.size() != 0));
      chk({tag, " valid_b"}, int'(vld_b), int'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk({tag, " bin_a"}, int'(bin_a), int'(sb[0].ba));
         chk({tag, " bin_b"}, int'(bin_b), int'(sb[0].bb));
         chk({tag, " zero"}, int'(zero_a), int'(sb[0].z));
         chk({tag, " multi"}, int'(multi_b), int'(sb[0].m));
      end
      chk({tag, " sticky_a"}, int'(sticky_a), m_sticky_a);
      chk({tag, " cnt_a"}, int'(cnt_a), m_cnt_a);
      chk({tag, " sticky_b"}, int'(sticky_b), m_sticky_b);
      chk({tag, " cnt_b"}, int'(cnt_b), m_cnt_b);
   endtask

   // One cycle: drive, check ready before the edge, advance the scoreboard on
   // the edge, check registered outputs just after it.
   task automatic drive(input string tag, input logic v, input logic [7:0] d, input logic r,
                        input logic c, input logic [2:0] eba, input logic [2:0] ebb,
                        input logic ez, input logic em);
      logic exp_rdy;
      logic acc;
      ent_t e;
      in_valid  = v;
      in_val    = d;
      out_ready = r;
      clr       = c;
      #3;
      exp_rdy = (sb.size() == 0) || r;
      chk({tag, " in_ready_a"}, int'(rdy_a), int'(exp_rdy));
      chk({tag, " in_ready_b"}, int'(rdy_b), int'(exp_rdy));
      @(posedge clk);
      acc = v && exp_rdy;
      if (sb.size() != 0 && r) void'(sb.pop_front());
      if (acc) begin
         e.ba = eba; e.bb = ebb; e.z = ez; e.m = em;
         sb.push_back(e);
      end
      if (c) begin
         m_sticky_a = 0; m_cnt_a = 0; m_sticky_b = 0; m_cnt_b = 0;
      end else if (acc) begin
         if (em) begin
            m_sticky_a = 1;
            if (m_cnt_a < 255) m_cnt_a++;
         end
         if (em || ez) begin
            m_sticky_b = 1;
            if (m_cnt_b < 3) m_cnt_b++;
         end
      end
      #1;
      chk_outputs(tag);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " valid_a"}, int'(vld_a), 0);
      chk({tag, " valid_b"}, int'(vld_b), 0);
      chk({tag, " bin_a"}, int'(bin_a), 0);
      chk({tag, " bin_b"}, int'(bin_b), 0);
      chk({tag, " zero"}, int'(zero_a | zero_b), 0);
      chk({tag, " multi"}, int'(multi_a | multi_b), 0);
      chk({tag, " sticky"}, int'(sticky_a | sticky_b), 0);
      chk({tag, " cnt_a"}, int'(cnt_a), 0);
      chk({tag, " cnt_b"}, int'(cnt_b), 0);
      chk({tag, " in_ready_a"}, int'(rdy_a), 1);
   endtask

   initial begin
      tbl[0] = '{8'b0001_0000, 3'd4, 3'd4, 1'b0, 1'b0};
      tbl[1] = '{8'b1000_0100, 3'd7, 3'd2, 1'b0, 1'b1};
      tbl[2] = '{8'b0000_0000, 3'd0, 3'd0, 1'b1, 1'b0};
      tbl[3] = '{8'b0000_0001, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[4] = '{8'b1000_0000, 3'd7, 3'd7, 1'b0, 1'b0};
      tbl[5] = '{8'b1111_1111, 3'd7, 3'd0, 1'b0, 1'b1};
      tbl[6] = '{8'b0000_0010, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[7] = '{8'b0100_0010, 3'd6, 3'd1, 1'b0, 1'b1};
      tbl[8] = '{8'b0001_1000, 3'd4, 3'd3, 1'b0, 1'b1};
      tbl[9] = '{8'b0010_0000, 3'd5, 3'd5, 1'b0, 1'b0};

      m_sticky_a = 0; m_cnt_a = 0; m_sticky_b = 0; m_cnt_b = 0;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_val = '0; out_ready = 1'b0;
      #12;
      chk_all_zero("reset");
      #4;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive($sformatf("vec%0d", i), 1'b1, tbl[i].val, 1'b1, 1'b0,
               tbl[i].bin_msb, tbl[i].bin_lsb, tbl[i].zero, tbl[i].multi);
      end
      drive("drain", 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

      // Backpressure with a bin=3 entry pending, then drain and reload together.
      drive("bp_load", 1'b1, 8'b0000_1000, 1'b0, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive($sformatf("bp_hold%0d", i), 1'b1, 8'b1111_1111, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      end
      drive("bp_reload", 1'b1, 8'b0000_0010, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
      drive("bp_next", 1'b1, 8'b0000_0000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);

      // Saturation of B's 2-bit counter, then clear racing a multi-hot accept.
      drive("clr0", 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive($sformatf("sat%0d", i), 1'b1, 8'b1000_0100, 1'b1, 1'b0, 3'd7, 3'd2, 1'b0, 1'b1);
      end
      chk("sat cnt_b", int'(cnt_b), 3);
      drive("clr_err", 1'b1, 8'b1000_0100, 1'b1, 1'b1, 3'd7, 3'd2, 1'b0, 1'b1);
      chk("clr multi_a", int'(multi_a), 1);
      chk("clr cnt_a", int'(cnt_a), 0);

      // Asynchronous reset with a stalled entry pending.
      drive("rst_load", 1'b1, 8'b0100_0000, 1'b0, 1'b0, 3'd6, 3'd6, 1'b0, 1'b0);
      drive("rst_load2", 1'b1, 8'b1100_0000, 1'b1, 1'b0, 3'd7, 3'd6, 1'b0, 1'b1);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      sb.delete();
      m_sticky_a = 0; m_cnt_a = 0; m_sticky_b = 0; m_cnt_b = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive("post_rst", 1'b1, 8'b0000_0100, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
      drive("post_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hpdcache_1hot_to_binary_pipe.md
Name: hpdcache_1hot_to_binary_pipe

Overview:
- Registered, handshaked one-hot-to-binary encoder for hpdcache way/requester select paths.
- Generalises the combinational encoder with:
  - a selectable priority direction;
  - detection of zero and multi-hot inputs;
  - a one-entry valid/ready output stage;
  - a sticky error flag and a saturating error counter for debug and assertion hooks.
- Sits between an arbiter or tag-compare stage and the consuming pipeline stage.

Parameters:
- N, 8, width of the one-hot input vector; legal range ≥1.
- MSB_FIRST, 1, priority when more than one bit is set. 1 = highest set index wins; 0 = lowest set index wins.
- ZERO_IS_ERR, 0, 1 = an all-zero input counts as an error.
- CNT_W, 8, width of the error counter; legal range ≥1.
- Log2N (localparam), N>1 ? clog2(N) : 1, width of the binary output.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of err_sticky_o and err_cnt_o.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  block can accept the input this cycle.
- in_val_i  in  N  one-hot, or malformed, input vector.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  consumer accepts the output entry.
- out_bin_o  out  Log2N  encoded index.
- out_zero_o  out  1  accepted vector had no bit set.
- out_multi_o  out  1  accepted vector had more than one bit set.
- err_sticky_o  out  1  an error has been accepted since the last reset or clear.
- err_cnt_o  out  CNT_W  saturating count of accepted erroneous vectors.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - out_valid_o, out_bin_o, out_zero_o, out_multi_o, err_sticky_o and err_cnt_o all go to 0.
  - in_ready_o is 1 while out_valid_o is 0.
- Ready and accept:
  - in_ready_o = !out_valid_o || out_ready_i. Purely combinational from out_ready_i; no bubble under back-to-back traffic.
  - accept = in_valid_i && in_ready_o.
- Output register:
  - On accept, the register loads the encoded index, zero flag and multi flag; out_valid_o is 1 the next cycle.
  - Latency is exactly 1 cycle from accept to out_valid_o.
  - If out_ready_i && !accept, out_valid_o clears.
  - Hold rule: while out_valid_o && !out_ready_i, all out_* outputs stay stable.
  - Simultaneous drain and accept: the register reloads with the new data and out_valid_o stays 1.
- Encoding:
  - MSB_FIRST=1: index of the highest set bit.
  - MSB_FIRST=0: index of the lowest set bit.
  - All-zero input: bin=0, zero=1, multi=0.
  - multi = popcount(in_val_i) > 1.
  - N=1: bin is always 0 and multi is always 0.
- Errors:
  - err_ev = accept && (multi || (ZERO_IS_ERR && zero)).
  - On err_ev, err_sticky_o is set and err_cnt_o increments.
  - err_cnt_o saturates at 2^CNT_W-1 and never wraps.
- Clear:
  - clr_i has priority over err_ev in the same cycle: both error outputs become 0 and the event is dropped.
  - clr_i does not affect the data path or out_valid_o.
- Input stability: in_val_i while in_valid_i is high and in_ready_o is low is ignored. No stability requirement on the source.
- Mid-operation reset: a pending output entry is discarded, and out_valid_o drops asynchronously.

Test Plan:
- Basic path (N=8, MSB_FIRST=1): in_val_i=8'b0001_0000 accepted at cycle t with out_ready_i=1 -> out_valid_o=1 at t+1, out_bin_o=4, zero=0, multi=0, err_cnt_o=0.
- Priority modes:
  - 8'b1000_0100 with MSB_FIRST=1 -> bin=7, multi=1, err_sticky_o=1, err_cnt_o=1.
  - Same vector with MSB_FIRST=0 -> bin=2.
- Backpressure: hold out_ready_i=0 for 5 cycles with entry bin=3 pending -> in_ready_o=0 and outputs frozen. Release with in_valid_i=1 and vector 8'b0000_0010 -> drain and reload in the same cycle, next cycle bin=1, no idle cycle.
- Zero input:
  - 8'b0 with ZERO_IS_ERR=0 -> bin=0, zero=1, err_cnt_o unchanged.
  - With ZERO_IS_ERR=1 -> err_cnt_o increments by 1.
- Saturation and clear (CNT_W=2): 5 multi-hot accepts -> err_cnt_o=3 and stays there. Assert clr_i together with a 6th multi-hot accept -> err_cnt_o=0 and err_sticky_o=0, while the data output still shows multi=1.
- Reset mid-operation: assert rst_ni=0 while out_valid_o=1 and out_ready_i=0 -> out_valid_o=0 immediately, all outputs 0. After release, in_ready_o=1.
